led_counter_ctrl: RTL and testbench

Run/pause/speed controller for the LED counter datapath. It turns the raw user push-button (KEY[1], active-low, bouncy) into a debounced command stream. It drives the counter with a one-cycle increment strobe at a selectable rate, plus a one-cycle clear strobe. It sits between the board pins and the LED counter inside the top level, replacing the fixed 0.2 s divider.

---
 rtl/led_counter_ctrl_pkg.sv | 10 +
 rtl/led_counter_ctrl_if.sv | 12 +
 rtl/led_counter_ctrl_debounce.sv | 34 +++
 rtl/led_counter_ctrl.sv | 83 ++++++++
 tb/tb_led_counter_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_counter_ctrl_pkg.sv
// led_ctrl_pkg: shared state/speed types and constants for the LED counter controller
package led_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } ctrl_state_t;
    typedef logic [1:0] speed_t;
    localparam int NUM_SPEEDS = 4;
endpackage

// File: rtl/led_counter_ctrl_if.sv
// led_counter_ctrl_if: raw key input and counter-control outputs of led_counter_ctrl
interface led_counter_ctrl_if;
    import led_ctrl_pkg::*;
    logic        btn_n;
    logic        cnt_tick;
    logic        cnt_clr;
    logic        running;
    speed_t      speed;
    ctrl_state_t state;
    modport master (output btn_n, input cnt_tick, cnt_clr, running, speed, state);
    modport slave  (input btn_n, output cnt_tick, cnt_clr, running, speed, state);
endinterface

// File: rtl/led_counter_ctrl_debounce.sv
// key_debounce: two-flop synchronizer plus stability counter for a bouncy active-low board key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    // bring the asynchronous key into the clock domain; idle level is released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], i_raw};
    end
    // accept a new level only after DEBOUNCE_CYCLES consecutive samples disagree with the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_db  <= 1'b1;
        end else if (r_sync[1] == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_db  <= r_sync[1];
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
    assign o_db = r_db;
endmodule

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: run/pause/speed controller producing tick and clear strobes for the LED counter
module led_counter_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int EXT_CLOCK_FREQ    = 50_000_000,
    parameter int BASE_PERIOD       = EXT_CLOCK_FREQ / 5,
    parameter int DEBOUNCE_CYCLES   = EXT_CLOCK_FREQ / 100,
    parameter int LONG_PRESS_CYCLES = EXT_CLOCK_FREQ
) (
    input logic               EXTCLK,
    input logic               rst_n,
    led_counter_ctrl_if.slave bus
);
    localparam int DW = $clog2(BASE_PERIOD);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    if (BASE_PERIOD < 8 || BASE_PERIOD % 8 != 0) begin : g_bad_period
        $error("BASE_PERIOD must be at least 8 and a multiple of 8");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    logic          w_db;
    logic          w_long;
    logic          w_short;
    logic          w_last;
    logic [DW:0]   w_period;
    logic [HW-1:0] r_hold;
    logic [DW-1:0] r_div;
    ctrl_state_t   r_state;
    speed_t        r_speed;
    logic          r_tick;
    logic          r_clr;
    logic          r_running;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (EXTCLK),
        .rst_n (rst_n),
        .i_raw (bus.btn_n),
        .o_db  (w_db)
    );
    assign w_period = (DW+1)'(BASE_PERIOD) >> r_speed;
    assign w_last   = {1'b0, r_div} == w_period - (DW+1)'(1);
    // long fires once as the hold count crosses the threshold; short needs a release before that
    assign w_long   = !w_db && r_hold == HW'(LONG_PRESS_CYCLES - 1);
    assign w_short  = w_db && r_hold != '0 && r_hold != HW'(LONG_PRESS_CYCLES);
    // measure how long the debounced key has been held, saturating at the long-press threshold
    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) r_hold <= '0;
        else if (w_db) r_hold <= '0;
        else if (r_hold != HW'(LONG_PRESS_CYCLES)) r_hold <= r_hold + HW'(1);
    end
    // mode FSM, speed select and rate divider; a long press overrides a tick due on the same cycle
    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_speed   <= '0;
            r_div     <= '0;
            r_tick    <= 1'b0;
            r_clr     <= 1'b0;
            r_running <= 1'b0;
        end else if (w_long) begin
            r_state   <= IDLE;
            r_speed   <= speed_t'((int'(r_speed) + 1) % NUM_SPEEDS);
            r_div     <= '0;
            r_tick    <= 1'b0;
            r_clr     <= 1'b1;
            r_running <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_tick <= r_state == RUN && w_last;
            if (r_state == RUN) r_div <= w_last ? '0 : r_div + DW'(1);
            else if (r_state == IDLE) r_div <= '0;
            if (w_short) begin
                r_state   <= r_state == RUN ? PAUSE : RUN;
                r_running <= r_state != RUN;
            end
        end
    end
    assign bus.cnt_tick = r_tick;
    assign bus.cnt_clr  = r_clr;
    assign bus.running  = r_running;
    assign bus.speed    = r_speed;
    assign bus.state    = r_state;
endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb_led_counter_ctrl: table-driven, directed and randomized checks of led_counter_ctrl against a press-level model
module tb_led_counter_ctrl;
    import led_ctrl_pkg::*;
    localparam int BP = 16;
    localparam int DB = 4;
    localparam int LP = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    led_counter_ctrl_if bus();
    led_counter_ctrl #(
        .BASE_PERIOD       (BP),
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .EXTCLK (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int seg_ticks = 0;
    int seg_clrs = 0;

    // reference model: debounced level, current press length, mode, speed, RUN cycles since start
    bit          hist[$];
    bit          m_db;
    int          m_hold;
    ctrl_state_t m_state;
    int          m_speed;
    int          m_runs;
    bit          e_tick;
    bit          e_clr;

    typedef struct {
        logic        btn;
        int          len;
        ctrl_state_t st;
        int          spd;
        int          ticks;
        int          clrs;
        logic        db;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (DB + 2) hist.push_back(1'b1);
        m_db = 1'b1;
        m_hold = 0;
        m_state = IDLE;
        m_speed = 0;
        m_runs = 0;
        e_tick = 1'b0;
        e_clr = 1'b0;
    endtask

    // one clock edge of the model, using the key level the DUT samples on that edge
    task automatic step();
        bit lng, sht, flip;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lng = !m_db && m_hold == LP - 1;
        sht = m_db && m_hold > 0 && m_hold < LP;
        e_tick = 1'b0;
        e_clr = 1'b0;
        if (lng) begin
            e_clr = 1'b1;
            m_speed = (m_speed + 1) % 4;
            m_state = IDLE;
            m_runs = 0;
        end else begin
            if (m_state == RUN) begin
                m_runs++;
                e_tick = (m_runs % (BP >> m_speed)) == 0;
            end else if (m_state == IDLE) begin
                m_runs = 0;
            end
            if (sht) m_state = (m_state == RUN) ? PAUSE : RUN;
        end
        m_hold = m_db ? 0 : (m_hold < LP ? m_hold + 1 : LP);
        hist.push_back(bus.btn_n);
        if (hist.size() > DB + 2) void'(hist.pop_front());
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[i] == m_db) flip = 1'b0;
        if (flip) m_db = !m_db;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            step();
            @(negedge clk);
            check("cycle", {bus.cnt_tick, bus.cnt_clr, bus.running, bus.speed, bus.state},
                  {e_tick, e_clr, m_state == RUN, speed_t'(m_speed), m_state});
            seg_ticks += int'(bus.cnt_tick);
            seg_clrs += int'(bus.cnt_clr);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.btn_n = tbl[i].btn;
            seg_ticks = 0;
            seg_clrs = 0;
            cyc(tbl[i].len);
            check($sformatf("seg%0d_state", i), bus.state, tbl[i].st);
            check($sformatf("seg%0d_speed", i), bus.speed, tbl[i].spd);
            check($sformatf("seg%0d_ticks", i), seg_ticks, tbl[i].ticks);
            check($sformatf("seg%0d_clrs", i), seg_clrs, tbl[i].clrs);
            check($sformatf("seg%0d_db", i), dut.w_db, tbl[i].db);
        end
    endtask

    // assert reset between clock edges and expect every output to drop at once
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("async_rst", {bus.cnt_tick, bus.cnt_clr, bus.running, bus.speed, bus.state}, 0);
        cyc(3);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int lo;
        model_reset();
        bus.btn_n = 1'b1;
        tbl.push_back('{1'b1, 100, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b0,   3, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b1,   5, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b0,   3, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b1,   5, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b0,   3, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b1,   5, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b0,  10, IDLE,  0, 0, 0, 1'b0});
        tbl.push_back('{1'b1,   6, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b1,   1, RUN,   0, 0, 0, 1'b1});
        tbl.push_back('{1'b1,  16, RUN,   0, 1, 0, 1'b1});
        tbl.push_back('{1'b1,  48, RUN,   0, 3, 0, 1'b1});
        tbl.push_back('{1'b0,  60, IDLE,  1, 2, 1, 1'b0});
        tbl.push_back('{1'b1,  20, IDLE,  1, 0, 0, 1'b1});
        tbl.push_back('{1'b0,  10, IDLE,  1, 0, 0, 1'b0});
        tbl.push_back('{1'b1,   7, RUN,   1, 0, 0, 1'b1});
        tbl.push_back('{1'b1,   8, RUN,   1, 1, 0, 1'b1});
        tbl.push_back('{1'b1,  32, RUN,   1, 4, 0, 1'b1});
        tbl.push_back('{1'b0,  60, IDLE,  2, 5, 1, 1'b0});
        tbl.push_back('{1'b1,  20, IDLE,  2, 0, 0, 1'b1});
        tbl.push_back('{1'b0,  60, IDLE,  3, 0, 1, 1'b0});
        tbl.push_back('{1'b1,  20, IDLE,  3, 0, 0, 1'b1});
        tbl.push_back('{1'b0,  60, IDLE,  0, 0, 1, 1'b0});
        tbl.push_back('{1'b1,  20, IDLE,  0, 0, 0, 1'b1});
        tbl.push_back('{1'b0,  10, IDLE,  0, 0, 0, 1'b0});
        tbl.push_back('{1'b1,   7, RUN,   0, 0, 0, 1'b1});
        tbl.push_back('{1'b1,  20, RUN,   0, 1, 0, 1'b1});

        cyc(5);
        rst_n = 1'b1;
        apply(0, 11);

        // pause lands with the divider at 5, then resume finishes the remaining 11 cycles
        bus.btn_n = 1'b1;
        cyc(4);
        bus.btn_n = 1'b0;
        cyc(10);
        bus.btn_n = 1'b1;
        cyc(6);
        check("pre_pause_state", bus.state, RUN);
        cyc(1);
        check("pause_state", bus.state, PAUSE);
        check("pause_div", 32'(dut.r_div), 5);
        seg_ticks = 0;
        cyc(200);
        check("pause_ticks", seg_ticks, 0);
        bus.btn_n = 1'b0;
        cyc(10);
        bus.btn_n = 1'b1;
        cyc(6);
        check("pause_hold_state", bus.state, PAUSE);
        cyc(1);
        check("resume_state", bus.state, RUN);
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (bus.cnt_tick) begin
                first = i;
                break;
            end
        end
        check("resume_latency", first, 11);

        apply(12, 26);

        async_reset();
        seg_ticks = 0;
        cyc(40);
        check("post_rst_ticks", seg_ticks, 0);
        check("post_rst_state", bus.state, IDLE);

        // random presses of glitch, short and long length with bouncy leading edges
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 2))
                0: lo = $urandom_range(1, 6);
                1: lo = $urandom_range(8, 30);
                default: lo = $urandom_range(42, 70);
            endcase
            for (int i = 0; i < lo; i++) begin
                bus.btn_n = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc(1);
            end
            if (p == 25) async_reset();
            bus.btn_n = 1'b1;
            cyc($urandom_range(3, 60));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
